// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial unloader: FSM encoding, bit-order tags, counter sizing.
package serial_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam bit LSB_FIRST     = 1'b0;
  localparam bit MSB_FIRST_ORD = 1'b1;

  // Counter must hold 0..size-1; a one-bit word still needs a 1-bit counter.
  function automatic int cnt_width(input int size);
    return (size <= 1) ? 1 : $clog2(size);
  endfunction

endpackage

// File: rtl/word_serializer_if.sv
// Load (word-wide) and serial (bit-wide) handshakes plus status between producer, serializer and consumer.
interface word_serializer_if #(
  parameter int SIZE = 4
);
  logic            load_valid;
  logic            load_ready;
  logic [SIZE-1:0] load_val;
  logic            ser_valid;
  logic            ser_ready;
  logic            ser_bit;
  logic            ser_last;
  logic            busy;
  logic            done;

  modport master (
    output load_valid, load_val, ser_ready,
    input  load_ready, ser_valid, ser_bit, ser_last, busy, done
  );

  modport slave (
    input  load_valid, load_val, ser_ready,
    output load_ready, ser_valid, ser_bit, ser_last, busy, done
  );
endinterface

// File: rtl/word_serializer_piso_shifter.sv
// Parallel-load shift register; out_bit is the end selected by MSB_FIRST, vacated bits fill with zero.
module piso_shifter
  import serial_pkg::*;
#(
  parameter int SIZE      = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic [SIZE-1:0] i_load_val,
  input  logic            i_shift,
  output logic            o_out_bit
);
  localparam bit ORD = (MSB_FIRST != 0) ? MSB_FIRST_ORD : LSB_FIRST;

  logic [SIZE-1:0] r_shreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= i_load_val;
    end else if (i_shift) begin
      // Shift operators keep SIZE=1 legal: the single bit simply clears.
      r_shreg <= (ORD == MSB_FIRST_ORD) ? (r_shreg << 1) : (r_shreg >> 1);
    end
  end

  assign o_out_bit = (ORD == MSB_FIRST_ORD) ? r_shreg[SIZE-1] : r_shreg[0];

endmodule

// File: rtl/word_serializer.sv
// Parallel-in serial-out unloader: one word per load handshake, one bit per serial transfer, done pulse after the last bit.
module word_serializer
  import serial_pkg::*;
#(
  parameter int SIZE      = 4,
  parameter int MSB_FIRST = 0
) (
  input  logic           clk,
  input  logic           rst,
  word_serializer_if.slave bus
);
  localparam int CW = cnt_width(SIZE);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;
  logic            r_done;
  logic            w_load_hs;
  logic            w_xfer;
  logic            w_last;
  logic            w_out_bit;

  assign w_load_hs = bus.load_valid && (r_state == ST_IDLE);
  assign w_xfer    = (r_state == ST_SHIFT) && bus.ser_ready;
  assign w_last    = (r_state == ST_SHIFT) && (r_cnt == CW'(SIZE - 1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_load_hs)          w_state_nxt = ST_SHIFT;
      ST_SHIFT: if (w_xfer && w_last)   w_state_nxt = ST_IDLE;
      default:                          w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_xfer && w_last;
      if (w_load_hs || (w_xfer && w_last)) begin
        r_cnt <= '0;
      end else if (w_xfer) begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  piso_shifter #(
    .SIZE      (SIZE),
    .MSB_FIRST (MSB_FIRST)
  ) u_shifter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load_hs),
    .i_load_val (bus.load_val),
    .i_shift    (w_xfer),
    .o_out_bit  (w_out_bit)
  );

  // Every output decodes registered state only; no input reaches an output combinationally.
  assign bus.load_ready = (r_state == ST_IDLE);
  assign bus.ser_valid  = (r_state == ST_SHIFT);
  assign bus.ser_bit    = (r_state == ST_SHIFT) && w_out_bit;
  assign bus.ser_last   = w_last;
  assign bus.busy       = (r_state == ST_SHIFT);
  assign bus.done       = r_done;

endmodule
